alu_32_bit: RTL and testbench



---
 rtl/alu_32_bit_pkg.sv | 13 +
 rtl/alu_slice_1bit.sv | 44 ++++
 rtl/alu_32_bit.sv | 49 ++++
 tb/tb_alu_32_bit.sv | 129 ++++++++++++
 4 files changed

// File: rtl/alu_32_bit_pkg.sv
// Shared opcode encodings and datapath width for the 32-bit ALU.
package alu_32_bit_pkg;
   localparam int unsigned ALU_W = 32;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_INC = 3'b010;
   localparam logic [2:0] OP_DEC = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_NOT = 3'b111;
endpackage

// File: rtl/alu_slice_1bit.sv
// One bit of the ALU: B-operand select, full adder, and bitwise logic mux.
module alu_slice_1bit
   import alu_32_bit_pkg::*;
(
   input  logic       a_i,
   input  logic       b_i,
   input  logic [2:0] sel,
   input  logic       c_i,
   output logic       f_o,
   output logic       c_o
);

   logic b_m;
   logic sum;
   logic lgc;

   // sel[1:0] picks the adder's second operand: B, ~B, 0 or 1
   always_comb begin
      b_m = b_i;
      unique case (sel[1:0])
         2'b00: b_m = b_i;
         2'b01: b_m = ~b_i;
         2'b10: b_m = 1'b0;
         2'b11: b_m = 1'b1;
      endcase
   end

   assign sum = a_i ^ b_m ^ c_i;
   assign c_o = (a_i & b_m) | (a_i & c_i) | (b_m & c_i);

   always_comb begin
      lgc = 1'b0;
      unique case (sel)
         OP_AND:  lgc = a_i & b_i;
         OP_OR:   lgc = a_i | b_i;
         OP_XOR:  lgc = a_i ^ b_i;
         OP_NOT:  lgc = ~a_i;
         default: lgc = 1'b0;
      endcase
   end

   assign f_o = sel[2] ? lgc : sum;

endmodule

// File: rtl/alu_32_bit.sv
// Registered 32-bit ALU: ripple chain of 1-bit slices feeding a 33-bit output register.
module alu_32_bit
   import alu_32_bit_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ALU_W-1:0]  a,
   input  logic [ALU_W-1:0]  b,
   input  logic              S0,
   input  logic              S1,
   input  logic              S2,
   input  logic              Ci,
   output logic [ALU_W-1:0]  F,
   output logic              Co
);

   logic [2:0]       sel;
   logic [ALU_W:0]   carry;
   logic [ALU_W-1:0] f_d;
   logic             co_d;

   assign sel      = {S2, S1, S0};
   assign carry[0] = Ci;

   for (genvar i = 0; i < ALU_W; i++) begin : g_slice
      alu_slice_1bit u_slice (
         .a_i (a[i]),
         .b_i (b[i]),
         .sel (sel),
         .c_i (carry[i]),
         .f_o (f_d[i]),
         .c_o (carry[i+1])
      );
   end

   // Logic ops still ripple a carry through the chain; it is discarded here
   assign co_d = sel[2] ? 1'b0 : carry[ALU_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         F  <= '0;
         Co <= 1'b0;
      end else begin
         F  <= f_d;
         Co <= co_d;
      end
   end

endmodule

// File: tb/tb_alu_32_bit.sv
// Directed self-checking bench for alu_32_bit with a per-cycle arithmetic reference model.
module tb_alu_32_bit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [2:0]  op = '0;
   logic        Ci = 1'b0;
   logic [31:0] F;
   logic        Co;

   int total = 0;
   int bad   = 0;

   logic [32:0] model_q;
   logic        model_vld;

   alu_32_bit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .S0    (op[0]),
      .S1    (op[1]),
      .S2    (op[2]),
      .Ci    (Ci),
      .F     (F),
      .Co    (Co)
   );

   always #5 clk = ~clk;

   function automatic logic [32:0] model(input logic [2:0] o, input logic [31:0] x,
                                         input logic [31:0] y, input logic c);
      logic [32:0] xe;
      logic [32:0] ce;
      xe = {1'b0, x};
      ce = {32'd0, c};
      case (o)
         3'd0:    return xe + {1'b0, y} + ce;
         3'd1:    return xe + {1'b0, ~y} + ce;
         3'd2:    return xe + ce;
         3'd3:    return xe + 33'h0_FFFF_FFFF + ce;
         3'd4:    return {1'b0, x & y};
         3'd5:    return {1'b0, x | y};
         3'd6:    return {1'b0, x ^ y};
         default: return {1'b0, ~x};
      endcase
   endfunction

   task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got Co=%0b F=%08h, want Co=%0b F=%08h",
                  name, act[32], act[31:0], exp[32], exp[31:0]);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_vld <= 1'b0;
         model_q   <= '0;
      end else begin
         model_vld <= 1'b1;
         model_q   <= model(op, a, b, Ci);
      end
   end

   always @(negedge clk) begin
      if (model_vld) check("model", {Co, F}, model_q);
   end

   task automatic apply(input string name, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic c, input logic [32:0] exp);
      @(negedge clk);
      op = o; a = x; b = y; Ci = c;
      @(posedge clk);
      #1;
      check(name, {Co, F}, exp);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 check("reset_initial", {Co, F}, 33'd0);
      @(negedge clk) rst_n = 1'b1;

      apply("pre_reset_add", 3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, {1'b1, 32'h0000_0001});
      // mid-cycle asynchronous reset with nonzero inputs still applied
      #2 rst_n = 1'b0;
      #1 check("reset_async", {Co, F}, 33'd0);
      @(posedge clk);
      #1 check("reset_hold", {Co, F}, 33'd0);
      @(negedge clk) rst_n = 1'b1;

      apply("add_a",  3'b000, 32'h0101_0101, 32'h6161_6161, 1'b0, {1'b0, 32'h6262_6262});
      apply("add_b",  3'b000, 32'h0101_010F, 32'h6121_6061, 1'b0, {1'b0, 32'h6222_6170});
      apply("add_c",  3'b000, 32'h2501_0107, 32'h6161_6167, 1'b0, {1'b0, 32'h8662_626E});
      apply("add_co", 3'b000, 32'hA501_0107, 32'h6165_6167, 1'b0, {1'b1, 32'h0666_626E});
      apply("add_ci", 3'b000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, {1'b1, 32'h0000_0000});
      apply("sub_5_3", 3'b001, 32'd5, 32'd3, 1'b1, {1'b1, 32'h0000_0002});
      apply("sub_0_1", 3'b001, 32'd0, 32'd1, 1'b1, {1'b0, 32'hFFFF_FFFF});
      apply("inc",    3'b010, 32'h7FFF_FFFF, 32'h1234_5678, 1'b1, {1'b0, 32'h8000_0000});
      apply("inc_wrap", 3'b010, 32'hFFFF_FFFF, 32'h0, 1'b1, {1'b1, 32'h0000_0000});
      apply("dec",    3'b011, 32'h0000_0000, 32'h0, 1'b0, {1'b0, 32'hFFFF_FFFF});
      apply("dec_tfr", 3'b011, 32'h1357_9BDF, 32'h0, 1'b1, {1'b1, 32'h1357_9BDF});
      apply("and",    3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, {1'b0, 32'hF000_F000});
      apply("or",     3'b101, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, {1'b0, 32'hFFF0_FFF0});
      apply("xor",    3'b110, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, {1'b0, 32'h0FF0_0FF0});
      apply("not",    3'b111, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, {1'b0, 32'h0F0F_0F0F});
      apply("and_all1", 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, {1'b0, 32'hFFFF_FFFF});

      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         Ci = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
